mac_learn_table: RTL and testbench

//  Parametrised MAC learning/lookup table for the switch forwarding path: learns (source MAC -> ingress port),

---
 rtl/switch_pkg.sv | 23 ++
 rtl/min_hit_select.sv | 39 +++
 rtl/mac_learn_table.sv | 132 +++++++++++++
 tb/tb_mac_learn_table.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared switch types and default sizing for the MAC learning table.
package switch_pkg;

   localparam int unsigned DEF_NUM_PORTS = 4;
   localparam int unsigned DEF_DEPTH     = 16;
   localparam int unsigned DEF_ADDR_W    = 48;
   localparam int unsigned DEF_HIT_W     = 8;
   localparam int unsigned DEF_AGE_W     = 8;
   localparam int unsigned DEF_AGE_LIMIT = 200;
   localparam int unsigned DEF_PORT_W    = $clog2(DEF_NUM_PORTS);

   typedef logic [DEF_ADDR_W-1:0] mac_addr_t;
   typedef logic [DEF_PORT_W-1:0] port_t;

   typedef struct packed {
      logic                 valid;
      mac_addr_t            addr;
      port_t                port;
      logic [DEF_HIT_W-1:0] hit;
      logic [DEF_AGE_W-1:0] age;
   } mac_entry_t;

endpackage

// File: rtl/min_hit_select.sv
// Picks the least-hit valid entry (lowest index on ties) and the lowest free slot.
module min_hit_select
   import switch_pkg::*;
#(
   parameter  int unsigned DEPTH = DEF_DEPTH,
   parameter  int unsigned HIT_W = DEF_HIT_W,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0][HIT_W-1:0] hit,
   input  logic [DEPTH-1:0]            valid,
   output logic [IDX_W-1:0]            victim_idx,
   output logic [IDX_W-1:0]            free_idx,
   output logic                        free_found
);

   logic [HIT_W-1:0] best;
   logic             best_found;

   always_comb begin
      victim_idx = '0;
      free_idx   = '0;
      free_found = 1'b0;
      best       = '1;
      best_found = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!valid[i]) begin
            if (!free_found) begin
               free_idx   = IDX_W'(i);
               free_found = 1'b1;
            end
         end else if (!best_found || hit[i] < best) begin
            best       = hit[i];
            victim_idx = IDX_W'(i);
            best_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mac_learn_table.sv
// Fully associative MAC learn/lookup table with aging, per-port flush and LFU eviction.
module mac_learn_table
   import switch_pkg::*;
#(
   parameter  int unsigned NUM_PORTS = DEF_NUM_PORTS,
   parameter  int unsigned DEPTH     = DEF_DEPTH,
   parameter  int unsigned ADDR_W    = DEF_ADDR_W,
   parameter  int unsigned HIT_W     = DEF_HIT_W,
   parameter  int unsigned AGE_W     = DEF_AGE_W,
   parameter  int unsigned AGE_LIMIT = DEF_AGE_LIMIT,
   localparam int unsigned PORT_W    = $clog2(NUM_PORTS),
   localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              learn_req_i,
   input  logic [ADDR_W-1:0] learn_address_i,
   input  logic [PORT_W-1:0] learn_port_i,
   input  logic              read_req_i,
   input  logic [ADDR_W-1:0] read_address_i,
   output logic [PORT_W-1:0] read_port_o,
   output logic              read_port_valid_o,
   output logic              read_done_o,
   input  logic              age_tick_i,
   input  logic              flush_req_i,
   input  logic [PORT_W-1:0] flush_port_i,
   output logic              evict_valid_o,
   output logic [ADDR_W-1:0] evict_address_o,
   output logic [IDX_W:0]    entry_count_o
);

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [PORT_W-1:0] port;
      logic [HIT_W-1:0]  hit;
      logic [AGE_W-1:0]  age;
   } entry_t;

   entry_t tbl_q [DEPTH];
   entry_t tbl_d [DEPTH];

   logic [DEPTH-1:0][HIT_W-1:0] hit_vec;
   logic [DEPTH-1:0]            valid_vec;
   logic [DEPTH-1:0]            rd_match, lr_match, fl_match, expire, lr_wr;
   logic [IDX_W-1:0]            victim_idx, free_idx, alloc_idx;
   logic                        free_found, lr_any, evict_d;
   logic [PORT_W-1:0]           rd_port_d;
   logic [IDX_W:0]              cnt_d;

   always_comb begin
      rd_port_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         hit_vec[i]   = tbl_q[i].hit;
         valid_vec[i] = tbl_q[i].valid;
         rd_match[i]  = read_req_i && tbl_q[i].valid && (tbl_q[i].addr == read_address_i);
         lr_match[i]  = tbl_q[i].valid && (tbl_q[i].addr == learn_address_i);
         fl_match[i]  = flush_req_i && tbl_q[i].valid && (tbl_q[i].port == flush_port_i);
         expire[i]    = age_tick_i && tbl_q[i].valid && !rd_match[i] &&
                        (tbl_q[i].age == AGE_W'(AGE_LIMIT - 1));
         if (rd_match[i]) rd_port_d = rd_port_d | tbl_q[i].port;
      end
   end

   min_hit_select #(.DEPTH(DEPTH), .HIT_W(HIT_W)) u_min_hit_select (
      .hit        (hit_vec),
      .valid      (valid_vec),
      .victim_idx (victim_idx),
      .free_idx   (free_idx),
      .free_found (free_found)
   );

   assign lr_any    = |lr_match;
   assign alloc_idx = free_found ? free_idx : victim_idx;
   // No report when the victim was already being flushed or aged out on this edge.
   assign evict_d   = learn_req_i && !lr_any && !free_found &&
                      !fl_match[victim_idx] && !expire[victim_idx];

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         lr_wr[i] = learn_req_i && (lr_any ? lr_match[i] : (IDX_W'(i) == alloc_idx));
         tbl_d[i] = tbl_q[i];
         if (lr_wr[i]) begin
            tbl_d[i].valid = 1'b1;
            tbl_d[i].port  = learn_port_i;
            tbl_d[i].age   = '0;
            if (!lr_any) begin
               tbl_d[i].addr = learn_address_i;
               tbl_d[i].hit  = '0;
            end else if (rd_match[i] && tbl_q[i].hit != '1) begin
               tbl_d[i].hit = tbl_q[i].hit + 1'b1;
            end
         end else if (rd_match[i]) begin
            if (tbl_q[i].hit != '1) tbl_d[i].hit = tbl_q[i].hit + 1'b1;
            tbl_d[i].age   = '0;
            tbl_d[i].valid = !fl_match[i];
         end else if (fl_match[i]) begin
            tbl_d[i].valid = 1'b0;
         end else if (age_tick_i && tbl_q[i].valid) begin
            tbl_d[i].age   = tbl_q[i].age + 1'b1;
            tbl_d[i].valid = !expire[i];
         end
      end
   end

   always_comb begin
      cnt_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++)
         cnt_d = cnt_d + (IDX_W+1)'(tbl_d[i].valid);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
         read_port_o       <= '0;
         read_port_valid_o <= 1'b0;
         read_done_o       <= 1'b0;
         evict_valid_o     <= 1'b0;
         evict_address_o   <= '0;
         entry_count_o     <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) tbl_q[i] <= tbl_d[i];
         read_port_o       <= rd_port_d;
         read_port_valid_o <= |rd_match;
         read_done_o       <= read_req_i;
         evict_valid_o     <= evict_d;
         if (evict_d) evict_address_o <= tbl_q[victim_idx].addr;
         entry_count_o     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mac_learn_table.sv
// Directed and random stimulus for mac_learn_table against an array-based table model.
module tb_mac_learn_table;

   localparam int DEPTH = 16;
   localparam int HMAX  = 3;
   localparam int LIM   = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        learn_req_i = 1'b0;
   logic [47:0] learn_address_i = '0;
   logic [1:0]  learn_port_i = '0;
   logic        read_req_i = 1'b0;
   logic [47:0] read_address_i = '0;
   logic [1:0]  read_port_o;
   logic        read_port_valid_o;
   logic        read_done_o;
   logic        age_tick_i = 1'b0;
   logic        flush_req_i = 1'b0;
   logic [1:0]  flush_port_i = '0;
   logic        evict_valid_o;
   logic [47:0] evict_address_o;
   logic [4:0]  entry_count_o;

   int n_cmp = 0;
   int n_err = 0;

   bit          m_v [DEPTH];
   logic [47:0] m_a [DEPTH];
   int          m_p [DEPTH];
   int          m_h [DEPTH];
   int          m_g [DEPTH];

   mac_learn_table #(.NUM_PORTS(4), .DEPTH(DEPTH), .ADDR_W(48), .HIT_W(2), .AGE_W(8), .AGE_LIMIT(LIM)) dut (
      .clk               (clk),
      .rst               (rst),
      .learn_req_i       (learn_req_i),
      .learn_address_i   (learn_address_i),
      .learn_port_i      (learn_port_i),
      .read_req_i        (read_req_i),
      .read_address_i    (read_address_i),
      .read_port_o       (read_port_o),
      .read_port_valid_o (read_port_valid_o),
      .read_done_o       (read_done_o),
      .age_tick_i        (age_tick_i),
      .flush_req_i       (flush_req_i),
      .flush_port_i      (flush_port_i),
      .evict_valid_o     (evict_valid_o),
      .evict_address_o   (evict_address_o),
      .entry_count_o     (entry_count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < DEPTH; i++) if (m_v[i]) c++;
      return c;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      learn_req_i = 0; read_req_i = 0; age_tick_i = 0; flush_req_i = 0;
      for (int i = 0; i < DEPTH; i++) begin
         m_v[i] = 0; m_a[i] = '0; m_p[i] = 0; m_h[i] = 0; m_g[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_done", read_done_o, 0);
      chk("rst_pvalid", read_port_valid_o, 0);
      chk("rst_port", read_port_o, 0);
      chk("rst_evict", evict_valid_o, 0);
      chk("rst_count", entry_count_o, 0);
      rst = 1'b0;
   endtask

   // One clock of stimulus; the model predicts outputs from the table contents seen before the edge.
   task automatic step(input bit lr, input logic [47:0] la, input int lp,
                       input bit rr, input logic [47:0] ra,
                       input bit tk, input bit fl, input int fp);
      int  j, k, tgt, vic;
      bit  newe, full, epv, ev, rh, fh;
      int  ep;
      logic [47:0] eva;
      learn_req_i = lr; learn_address_i = la; learn_port_i = 2'(lp);
      read_req_i = rr; read_address_i = ra;
      age_tick_i = tk; flush_req_i = fl; flush_port_i = 2'(fp);

      j = -1;
      if (rr) for (int i = 0; i < DEPTH; i++) if (m_v[i] && m_a[i] == ra) j = i;
      epv = (j >= 0);
      ep  = epv ? m_p[j] : 0;

      k = -1; tgt = -1; newe = 0; full = 0; ev = 0; eva = '0;
      for (int i = 0; i < DEPTH; i++) if (m_v[i] && m_a[i] == la) k = i;
      if (lr) begin
         if (k >= 0) tgt = k;
         else begin
            newe = 1;
            for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) tgt = i;
            if (tgt < 0) begin
               full = 1; vic = 0;
               for (int i = 1; i < DEPTH; i++) if (m_h[i] < m_h[vic]) vic = i;
               tgt = vic;
            end
         end
         if (full) begin
            ev  = !(fl && m_p[tgt] == fp) && !(tk && m_g[tgt] == LIM - 1 && !(epv && j == tgt));
            eva = m_a[tgt];
         end
      end

      for (int i = 0; i < DEPTH; i++) begin
         rh = epv && (j == i);
         fh = fl && m_v[i] && (m_p[i] == fp);
         if (lr && i == tgt) begin
            m_v[i] = 1; m_p[i] = lp; m_g[i] = 0;
            if (newe) begin m_a[i] = la; m_h[i] = 0; end
            else if (rh && m_h[i] < HMAX) m_h[i]++;
         end else if (rh) begin
            if (m_h[i] < HMAX) m_h[i]++;
            m_g[i] = 0;
            if (fh) m_v[i] = 0;
         end else if (fh) begin
            m_v[i] = 0;
         end else if (tk && m_v[i]) begin
            m_g[i]++;
            if (m_g[i] == LIM) m_v[i] = 0;
         end
      end

      @(posedge clk);
      #1;
      chk("read_done", read_done_o, rr);
      chk("read_valid", read_port_valid_o, epv);
      chk("read_port", read_port_o, ep);
      chk("evict_valid", evict_valid_o, ev);
      if (ev) chk("evict_addr", evict_address_o, eva);
      chk("entry_count", entry_count_o, model_count());
   endtask

   task automatic idle();
      step(0, '0, 0, 0, '0, 0, 0, 0);
   endtask

   task automatic learn(input logic [47:0] a, input int p);
      step(1, a, p, 0, '0, 0, 0, 0);
   endtask

   task automatic lookup(input logic [47:0] a);
      step(0, '0, 0, 1, a, 0, 0, 0);
   endtask

   initial begin
      do_reset();

      // basic learn then lookup
      learn(48'h1001, 1);
      lookup(48'h1001);
      chk("t1_done", read_done_o, 1);
      chk("t1_valid", read_port_valid_o, 1);
      chk("t1_port", read_port_o, 1);
      chk("t1_count", entry_count_o, 1);

      // fill, skew hit counts, overflow into LFU eviction
      do_reset();
      for (int i = 1; i <= 16; i++) learn(48'h1000 + 48'(i), i % 4);
      chk("t2_full", entry_count_o, 16);
      for (int i = 1; i <= 16; i++)
         for (int r = 0; r < i - 1; r++) lookup(48'h1000 + 48'(i));
      learn(48'h1011, 0);
      chk("t2_first_victim", evict_address_o, 48'h1001);
      for (int i = 18; i <= 20; i++) learn(48'h1000 + 48'(i), 1);
      for (int i = 1; i <= 20; i++) lookup(48'h1000 + 48'(i));
      chk("t2_count", entry_count_o, 16);

      // re-learn of a present address while full
      learn(48'h1005, 3);
      chk("t5_no_evict", evict_valid_o, 0);
      lookup(48'h1005);
      chk("t5_port", read_port_o, 3);
      learn(48'h1030, 2);
      idle();

      // aging with a read refresh between ticks
      do_reset();
      learn(48'h2001, 0);
      learn(48'h2002, 1);
      step(0, '0, 0, 0, '0, 1, 0, 0);
      lookup(48'h2002);
      step(0, '0, 0, 0, '0, 1, 0, 0);
      step(0, '0, 0, 0, '0, 1, 0, 0);
      lookup(48'h2001);
      chk("t3_expired", read_port_valid_o, 0);
      lookup(48'h2002);
      chk("t3_alive", read_port_valid_o, 1);
      chk("t3_count", entry_count_o, 1);

      // per-port flush, then flush concurrent with a learn on the flushed port
      do_reset();
      learn(48'h3001, 2);
      learn(48'h3002, 2);
      learn(48'h3003, 0);
      step(0, '0, 0, 0, '0, 0, 1, 2);
      lookup(48'h3001);
      lookup(48'h3002);
      chk("t4_flushed", read_port_valid_o, 0);
      lookup(48'h3003);
      chk("t4_kept", read_port_valid_o, 1);
      step(1, 48'h3004, 2, 0, '0, 0, 1, 2);
      lookup(48'h3004);
      chk("t4_learn_survives", read_port_valid_o, 1);
      chk("t4_learn_port", read_port_o, 2);

      // same-cycle read/learn of new address and read/learn of existing address
      step(1, 48'h3005, 1, 1, 48'h3005, 0, 0, 0);
      chk("same_new_miss", read_port_valid_o, 0);
      step(1, 48'h3003, 3, 1, 48'h3003, 0, 0, 0);
      chk("same_old_port", read_port_o, 0);

      // hit saturation decides the victim
      do_reset();
      for (int i = 0; i < 16; i++) learn(48'h4000 + 48'(i), 1);
      for (int r = 0; r < 5; r++) lookup(48'h4000);
      for (int i = 1; i < 16; i++) begin
         lookup(48'h4000 + 48'(i));
         lookup(48'h4000 + 48'(i));
      end
      learn(48'h4100, 2);
      chk("t6_evict", evict_valid_o, 1);
      chk("t6_victim", evict_address_o, 48'h4001);

      // reset while a lookup is in flight
      read_req_i = 1; read_address_i = 48'h4000;
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_rst_done", read_done_o, 0);
      chk("t6_rst_valid", read_port_valid_o, 0);
      do_reset();

      // random mix over a small address pool
      for (int n = 0; n < 1500; n++) begin
         step($urandom_range(0, 1), 48'hA000 + 48'($urandom_range(0, 23)), $urandom_range(0, 3),
              $urandom_range(0, 1), 48'hA000 + 48'($urandom_range(0, 23)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0), $urandom_range(0, 3));
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
